// File: rtl/sort_pkg.sv
// Shared definitions for the best-3 zone sorter and its zone scheduler.
package sort_pkg;
    localparam int SORT_BWR  = 6;
    localparam int SORT_BPOW = 6;

    typedef logic [SORT_BWR-1:0] rank_t;
    typedef logic [SORT_BPOW:0]  winidx_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
endpackage

// File: rtl/sort_zone_sched_if.sv
// Job, sorter-mux and publish signals between the scheduler and its neighbours.
interface sort_zone_sched_if #(
    parameter int ZONES = 4,
    parameter int BWR   = 6,
    parameter int BPOW  = 6
);
    import sort_pkg::*;
    localparam int ZW = $clog2(ZONES);

    logic                              start;
    logic                              busy;
    logic                              overrun;
    logic [ZW-1:0]                     zone_sel;
    logic                              issue_vld;
    logic [2:0][BWR-1:0]               srt_q;
    logic [2:0][BPOW:0]                srt_num;
    logic [ZONES-1:0][2:0][BWR-1:0]    ph_q;
    logic [ZONES-1:0][2:0][BPOW:0]     ph_num;
    logic                              done;

    modport slave (
        input  start, srt_q, srt_num,
        output busy, overrun, zone_sel, issue_vld, ph_q, ph_num, done
    );
    modport master (
        output start, srt_q, srt_num,
        input  busy, overrun, zone_sel, issue_vld, ph_q, ph_num, done
    );
endinterface

// File: rtl/sort_tag_pipe.sv
// Delay line of {valid, zone} tags matching the shared sorter latency.
module sort_tag_pipe
    import sort_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int ZW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [ZW-1:0] in_zone,
    output logic          out_vld,
    output logic [ZW-1:0] out_zone
);
    logic [DEPTH-1:0]         vld_pipe;
    logic [DEPTH-1:0][ZW-1:0] zone_pipe;

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_pipe  <= '0;
                    zone_pipe <= '0;
                end else begin
                    vld_pipe  <= in_vld;
                    zone_pipe <= in_zone;
                end
            end
        end else begin : g_shift
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_pipe  <= '0;
                    zone_pipe <= '0;
                end else begin
                    vld_pipe  <= {vld_pipe[DEPTH-2:0], in_vld};
                    zone_pipe <= {zone_pipe[DEPTH-2:0], in_zone};
                end
            end
        end
    endgenerate

    assign out_vld  = vld_pipe[DEPTH-1];
    assign out_zone = zone_pipe[DEPTH-1];
endmodule

// File: rtl/sort_zone_sched.sv
// Sequences the zones of a sector through one shared best-3 sorter and
// publishes all zone winners together with a single done pulse.
module sort_zone_sched
    import sort_pkg::*;
#(
    parameter int ZONES    = 4,
    parameter int SORT_LAT = 3,
    parameter int BWR      = SORT_BWR,
    parameter int BPOW     = SORT_BPOW
) (
    input logic             clk,
    input logic             rst,
    sort_zone_sched_if.slave bus
);
    localparam int            ZW   = $clog2(ZONES);
    localparam logic [ZW-1:0] LAST = ZW'(ZONES - 1);

    state_t                         state;
    logic                           tag_vld;
    logic [ZW-1:0]                  tag_zone;
    logic                           accept;
    logic                           last_cap;
    logic [ZONES-1:0][2:0][BWR-1:0] stg_q;
    logic [ZONES-1:0][2:0][BPOW:0]  stg_num;

    // The done cycle is already IDLE, so back-to-back starts need no special case.
    assign accept   = bus.start && (state == IDLE);
    assign last_cap = tag_vld && (tag_zone == LAST);

    sort_tag_pipe #(.DEPTH(SORT_LAT), .ZW(ZW)) u_tag (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (bus.issue_vld),
        .in_zone  (bus.zone_sel),
        .out_vld  (tag_vld),
        .out_zone (tag_zone)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.busy      <= 1'b0;
            bus.overrun   <= 1'b0;
            bus.issue_vld <= 1'b0;
            bus.zone_sel  <= '0;
            bus.done      <= 1'b0;
            bus.ph_q      <= '0;
            bus.ph_num    <= '0;
            stg_q         <= '0;
            stg_num       <= '0;
        end else begin
            bus.done <= last_cap;
            if (bus.start && !accept)
                bus.overrun <= 1'b1;

            if (accept)
                bus.busy <= 1'b1;
            else if (bus.done)
                bus.busy <= 1'b0;

            if (tag_vld) begin
                stg_q[tag_zone]   <= bus.srt_q;
                stg_num[tag_zone] <= bus.srt_num;
            end

            // Last zone's result bypasses staging so publish lands one cycle after capture.
            if (last_cap) begin
                for (int z = 0; z < ZONES; z++) begin
                    bus.ph_q[z]   <= (z == ZONES - 1) ? bus.srt_q   : stg_q[z];
                    bus.ph_num[z] <= (z == ZONES - 1) ? bus.srt_num : stg_num[z];
                end
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= ISSUE;
                        bus.issue_vld <= 1'b1;
                        bus.zone_sel  <= '0;
                    end
                end
                ISSUE: begin
                    if (bus.zone_sel == LAST) begin
                        state         <= DRAIN;
                        bus.issue_vld <= 1'b0;
                        bus.zone_sel  <= '0;
                    end else begin
                        bus.zone_sel <= bus.zone_sel + ZW'(1);
                    end
                end
                DRAIN: begin
                    if (last_cap)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_zone_sched.sv
// Directed bench for the zone scheduler: default build plus a ZONES=3/SORT_LAT=1 build.
module tb_sort_zone_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sort_zone_sched_if #(.ZONES(4), .BWR(6), .BPOW(6)) ifa ();
    sort_zone_sched_if #(.ZONES(3), .BWR(6), .BPOW(6)) ifb ();

    sort_zone_sched #(.ZONES(4), .SORT_LAT(3), .BWR(6), .BPOW(6)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    sort_zone_sched #(.ZONES(3), .SORT_LAT(1), .BWR(6), .BPOW(6)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    typedef struct {
        logic [127:0] q;
        logic [127:0] n;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   total = 0;
    int   bad   = 0;
    int   seed_a = 0;
    int   seed_b = 0;
    logic [127:0] held_q, held_n;

    // Sorter models: fixed latency, results derived from the issued zone.
    logic [2:0]      mv_a = '0;
    logic [2:0][1:0] mz_a = '0;
    logic            mv_b = 1'b0;
    logic [1:0]      mz_b = '0;

    function automatic logic [5:0] rq(int z, int k, int s);
        return 6'(z + 3 - k + s);
    endfunction

    function automatic logic [6:0] rn(int z, int k, int s);
        return 7'(z * 8 + k + s);
    endfunction

    always @(posedge clk) begin
        mv_a <= {mv_a[1:0], ifa.issue_vld};
        mz_a <= {mz_a[1:0], ifa.zone_sel};
        mv_b <= ifb.issue_vld;
        mz_b <= ifb.zone_sel;
    end

    always_comb begin
        ifa.srt_q   = '1;
        ifa.srt_num = '1;
        ifb.srt_q   = '1;
        ifb.srt_num = '1;
        for (int k = 0; k < 3; k++) begin
            if (mv_a[2] === 1'b1) begin
                ifa.srt_q[k]   = rq(int'(mz_a[2]), k, seed_a);
                ifa.srt_num[k] = rn(int'(mz_a[2]), k, seed_a);
            end
            if (mv_b === 1'b1) begin
                ifb.srt_q[k]   = rq(int'(mz_b), k, seed_b);
                ifb.srt_num[k] = rn(int'(mz_b), k, seed_b);
            end
        end
    end

    function automatic exp_t exp_job(int s, int zones);
        exp_t e;
        e.q = '0;
        e.n = '0;
        for (int z = 0; z < zones; z++)
            for (int k = 0; k < 3; k++) begin
                e.q[(z*3+k)*6 +: 6] = rq(z, k, s);
                e.n[(z*3+k)*7 +: 7] = rn(z, k, s);
            end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(bit b);
        exp_t e;
        total++;
        assert ((b ? sb_b.size() : sb_a.size()) > 0) else begin
            bad++;
            $error("FAIL scoreboard_empty: got 0 want 1 entries");
        end
        if (!b && sb_a.size() > 0) begin
            e = sb_a.pop_front();
            chk("a_ph_q",   128'(ifa.ph_q),   e.q);
            chk("a_ph_num", 128'(ifa.ph_num), e.n);
            held_q = e.q;
            held_n = e.n;
        end
        if (b && sb_b.size() > 0) begin
            e = sb_b.pop_front();
            chk("b_ph_q",   128'(ifb.ph_q),   e.q);
            chk("b_ph_num", 128'(ifb.ph_num), e.n);
        end
    endtask

    task automatic chk_zero_a(string tag);
        chk({tag, "_busy"},    128'(ifa.busy),      '0);
        chk({tag, "_overrun"}, 128'(ifa.overrun),   '0);
        chk({tag, "_issue"},   128'(ifa.issue_vld), '0);
        chk({tag, "_zsel"},    128'(ifa.zone_sel),  '0);
        chk({tag, "_done"},    128'(ifa.done),      '0);
        chk({tag, "_ph_q"},    128'(ifa.ph_q),      '0);
        chk({tag, "_ph_num"},  128'(ifa.ph_num),    '0);
    endtask

    initial begin
        rst       = 1'b1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        step();
        step();
        chk_zero_a("reset");
        chk("reset_b_done", 128'(ifb.done), '0);
        chk("reset_b_ph_q", 128'(ifb.ph_q), '0);
        rst = 1'b0;
        step();

        // Single job followed by a back-to-back job started in the done cycle.
        seed_a    = 0;
        ifa.start = 1'b1;
        sb_a.push_back(exp_job(0, 4));
        for (int c = 1; c <= 17; c++) begin
            step();
            ifa.start = 1'b0;
            chk("issue_vld", 128'(c <= 4 || (c >= 9 && c <= 12)), 128'(ifa.issue_vld));
            if (c <= 4)            chk("zone_sel", 128'(ifa.zone_sel), 128'(c - 1));
            if (c >= 9 && c <= 12) chk("zone_sel2", 128'(ifa.zone_sel), 128'(c - 9));
            chk("busy", 128'(ifa.busy), 128'(c <= 16));
            chk("done", 128'(ifa.done), 128'(c == 8 || c == 16));
            if (c == 8)
                chk("ph_q2", 128'(ifa.ph_q[2]), 128'({6'd3, 6'd4, 6'd5}));
            if (c == 8 || c == 16)
                pop_chk(1'b0);
            else if (c > 8 && c < 16) begin
                chk("held_q", 128'(ifa.ph_q), held_q);
                chk("held_n", 128'(ifa.ph_num), held_n);
            end
            if (c == 8) begin
                seed_a    = 10;
                ifa.start = 1'b1;
                sb_a.push_back(exp_job(10, 4));
            end
        end

        // Start while busy is dropped and flags overrun.
        seed_a    = 20;
        ifa.start = 1'b1;
        sb_a.push_back(exp_job(20, 4));
        for (int c = 1; c <= 12; c++) begin
            step();
            ifa.start = 1'b0;
            chk("overrun", 128'(ifa.overrun), 128'(c >= 4));
            chk("ovr_done", 128'(ifa.done), 128'(c == 8));
            chk("ovr_busy", 128'(ifa.busy), 128'(c <= 8));
            chk("ovr_issue", 128'(ifa.issue_vld), 128'(c <= 4));
            if (c == 8) pop_chk(1'b0);
            if (c == 3) ifa.start = 1'b1;
        end

        // Reset in the middle of a job, then a fresh job.
        seed_a    = 30;
        ifa.start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            step();
            ifa.start = 1'b0;
            rst       = 1'b0;
            if (c < 5)  chk("mid_busy", 128'(ifa.busy), 128'(1));
            if (c == 6) chk_zero_a("midrst");
            if (c >= 6) begin
                chk("midrst_done", 128'(ifa.done), 128'(c == 15));
                chk("midrst_busy", 128'(ifa.busy), 128'(c >= 8));
            end
            if (c == 15) pop_chk(1'b0);
            if (c == 5) rst = 1'b1;
            if (c == 7) begin
                seed_a    = 31;
                ifa.start = 1'b1;
                sb_a.push_back(exp_job(31, 4));
            end
        end

        // Start coincident with reset is ignored.
        step();
        rst       = 1'b1;
        ifa.start = 1'b1;
        step();
        rst       = 1'b0;
        ifa.start = 1'b0;
        chk("rststart_busy", 128'(ifa.busy), '0);
        chk("rststart_issue", 128'(ifa.issue_vld), '0);
        step();
        chk("rststart_busy2", 128'(ifa.busy), '0);

        // ZONES=3, SORT_LAT=1 build.
        seed_b    = 5;
        ifb.start = 1'b1;
        sb_b.push_back(exp_job(5, 3));
        for (int c = 1; c <= 7; c++) begin
            step();
            ifb.start = 1'b0;
            chk("b_issue", 128'(ifb.issue_vld), 128'(c <= 3));
            if (c <= 3) chk("b_zone_sel", 128'(ifb.zone_sel), 128'(c - 1));
            chk("b_zsel_lt3", 128'(ifb.zone_sel != 2'd3), 128'(1));
            chk("b_done", 128'(ifb.done), 128'(c == 5));
            chk("b_busy", 128'(ifb.busy), 128'(c <= 5));
            if (c == 5) pop_chk(1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sort_zone_sched.md
# sort_zone_sched

Time-multiplexing scheduler that shares one best-3 zone sorter across the four zones of a sector, in place of four parallel sorter instances. On a per-BX start strobe it issues zones 0..3 to the shared sorter on consecutive cycles and tracks each zone through the sorter pipeline with a tag. It captures each zone's three winners and publishes all zones together with a single-cycle done pulse. The block sits between the pattern-rank producers and the track builder, and drives the rank-select mux in front of the shared sorter.

## Interface
Parameters:
- ZONES, 4: number of zones sequenced per job.
- SORT_LAT, 3: fixed latency of the shared sorter, in cycles from issue to result.
- BWR, 6: rank width.
- BPOW, 6: winner-index width is BPOW+1.

Ports:
- clk  in  1  sector clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job request, once per BX.
- busy  out  1  job in progress.
- overrun  out  1  sticky; set by a start that is not accepted.
- zone_sel  out  $clog2(ZONES)  zone driven into the sorter input mux.
- issue_vld  out  1  zone_sel is valid this cycle.
- srt_q  in  [2:0][BWR]  sorter winner ranks.
- srt_num  in  [2:0][BPOW+1]  sorter winner indices.
- ph_q  out  [ZONES-1:0][2:0][BWR]  published ranks.
- ph_num  out  [ZONES-1:0][2:0][BPOW+1]  published indices.
- done  out  1  one-cycle pulse; ph_q/ph_num updated this cycle.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - start → ISSUE with issue counter = 0.
  - Otherwise stay in IDLE.
- ISSUE:
  - issue_vld = 1 and zone_sel = counter.
  - Counter increments each cycle.
  - After zone ZONES-1 → DRAIN.
- DRAIN:
  - Wait until the tag pipe empties.
  - The cycle the last zone is captured → IDLE.
- Tag pipe:
  - A SORT_LAT-deep shift register of {valid, zone}, loaded from {issue_vld, zone_sel}.
  - When a valid tag emerges, srt_q/srt_num are written into staging slot [zone].
- Publish:
  - The cycle after the capture of zone ZONES-1, staging is copied to ph_q/ph_num and done = 1.
  - Outputs hold between done pulses.
  - Staging writes never disturb the published outputs.
- busy: high from the cycle after an accepted start through the done cycle inclusive.
- Start acceptance:
  - Accepted in IDLE, or in the done cycle (back-to-back jobs).
  - A start in the done cycle begins issuing the next cycle; the pipe is already empty.
  - A start at any other time while busy is dropped and sets overrun.
  - overrun is cleared only by rst.
- Every capture uses its tag; captured results are never attributed by cycle counting.

## Timing
- Start accepted at cycle 0:
  - issue_vld is high at cycles 1..ZONES.
  - zone z is issued at cycle 1+z.
  - zone z result is sampled at cycle 1+z+SORT_LAT.
  - done is high at cycle ZONES+SORT_LAT+1 (cycle 8 at the defaults).
- Minimum start spacing: ZONES+SORT_LAT+1 cycles (8 at the defaults).
- Reset values:
  - All outputs 0: busy, overrun, issue_vld, zone_sel, done, ph_q, ph_num.
  - State IDLE, tag pipe all-invalid, staging 0.
- Reset mid-job: the job is abandoned, no done pulse, published outputs become 0.
- A start asserted together with rst is ignored.
- zone_sel wraps at ZONES-1. With ZONES not a power of 2, the counter never exceeds ZONES-1.

## Structure
- Shared package sort_pkg holds:
  - the BWR/BPOW defaults and the state enum.
  - typedefs rank_t = logic [BWR-1:0] and winidx_t = logic [BPOW:0].
- The package is imported by this block and by the sorter.
- One sub-module, sort_tag_pipe: a parameterised delay line of {valid, zone}, depth SORT_LAT, cleared by rst.
- The sorter itself and the input mux live outside this block.

## Test plan
- Single job, defaults:
  - Stimulus: start at cycle 0. A sorter model returns srt_q = {z+1, z+2, z+3} for zone z after 3 cycles.
  - Required: zone_sel = 0, 1, 2, 3 at cycles 1-4; done at cycle 8; ph_q[2] = {3, 4, 5}; busy high over cycles 1-8.
- Back-to-back:
  - Stimulus: second start in the done cycle (cycle 8) with different data.
  - Required: second issue at cycles 9-12; second done at cycle 16; first results held over cycles 8-15.
- Overrun:
  - Stimulus: start at cycle 0, then start at cycle 3.
  - Required: overrun = 1 from cycle 4 and stays high; first job completes normally at cycle 8; no extra job.
- Reset mid-job:
  - Stimulus: rst at cycle 5.
  - Required: all outputs 0 from cycle 6; no done pulse; a new start at cycle 7 gives done at cycle 15.
- Parameter sweep:
  - Stimulus: SORT_LAT = 1 and ZONES = 3 (non-power-of-2).
  - Required: done at cycle 5; zone_sel never reaches 3; every zone's results are captured in the correct slot.
